// File: rtl/decode_stage_p.sv
// decode_stage_p: pipelined MIPS decode with register file, writeback bypass and load-use interlock
module decode_stage_p #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int REG_AW  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        opcode,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic [REG_AW-1:0] dest_reg,
    output logic              reg_dest,
    output logic              branch,
    output logic              branch_ne,
    output logic              jump,
    output logic              mem_read,
    output logic              mem_to_reg,
    output logic              mem_write,
    output logic              alu_src,
    output logic              reg_write,
    output logic [2:0]        alu_op,
    output logic              illegal,
    output logic              end_program
);
    typedef struct packed {
        logic [5:0]        opcode;
        logic [REG_AW-1:0] rs, rt, rd, dest;
        logic [4:0]        shamt;
        logic [5:0]        funct;
        logic [DATA_W-1:0] imm, rd1, rd2;
        logic [8:0]        ctl;
        logic [2:0]        alu_op;
        logic              illegal;
    } bundle_t;

    bundle_t           r_b, w_b;
    logic              r_out_valid, r_end;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic              w_end, w_uses_rt, w_hazard, w_accept;
    logic [DATA_W-1:0] w_sext, w_zext, w_lui, w_jimm;

    assign w_sext = DATA_W'($signed(instr[15:0]));
    assign w_zext = DATA_W'(instr[15:0]);
    assign w_lui  = DATA_W'({instr[15:0], 16'h0});
    assign w_jimm = DATA_W'(instr[25:0]);

    // ctl bits: reg_dest branch branch_ne jump mem_read mem_to_reg mem_write alu_src reg_write
    always_comb begin
        w_b        = '0;
        w_end      = 1'b0;
        w_b.opcode = instr[31:26];
        w_b.rs     = instr[21 +: REG_AW];
        w_b.rt     = instr[16 +: REG_AW];
        w_b.rd     = instr[11 +: REG_AW];
        w_b.shamt  = instr[10:6];
        w_b.funct  = instr[5:0];
        case (instr[31:26])
            6'h00: begin w_b.ctl = 9'b1_0000_0001; w_b.alu_op = 3'b010; end
            6'h23: begin w_b.ctl = 9'b0_0001_1011; w_b.imm = w_sext; end
            6'h2B: begin w_b.ctl = 9'b0_0000_0110; w_b.imm = w_sext; end
            6'h04: begin w_b.ctl = 9'b0_1000_0000; w_b.alu_op = 3'b001; w_b.imm = w_sext; end
            6'h05: begin w_b.ctl = 9'b0_1100_0000; w_b.alu_op = 3'b001; w_b.imm = w_sext; end
            6'h08: begin w_b.ctl = 9'b0_0000_0011; w_b.imm = w_sext; end
            6'h0C: begin w_b.ctl = 9'b0_0000_0011; w_b.alu_op = 3'b011; w_b.imm = w_zext; end
            6'h0D: begin w_b.ctl = 9'b0_0000_0011; w_b.alu_op = 3'b100; w_b.imm = w_zext; end
            6'h0A: begin w_b.ctl = 9'b0_0000_0011; w_b.alu_op = 3'b101; w_b.imm = w_sext; end
            6'h0F: begin w_b.ctl = 9'b0_0000_0011; w_b.alu_op = 3'b110; w_b.imm = w_lui; end
            6'h02: begin w_b.ctl = 9'b0_0010_0000; w_b.imm = w_jimm; end
            6'h3F: w_end = 1'b1;
            default: w_b.illegal = 1'b1;
        endcase
        w_b.dest = w_b.ctl[8] ? w_b.rd : w_b.rt;
        w_b.rd1  = (wb_en && wb_addr == w_b.rs && (w_b.rs != '0 || ZERO_REG == 0)) ? wb_data : r_regs[w_b.rs];
        w_b.rd2  = (wb_en && wb_addr == w_b.rt && (w_b.rt != '0 || ZERO_REG == 0)) ? wb_data : r_regs[w_b.rt];
    end

    assign w_uses_rt = instr[31:26] == 6'h00 || instr[31:26] == 6'h2B ||
                       instr[31:26] == 6'h04 || instr[31:26] == 6'h05;
    // a load still in the output stage cannot forward its data, so its consumer waits
    assign w_hazard  = in_valid && r_out_valid && r_b.ctl[4] && r_b.dest != '0 &&
                       (r_b.dest == w_b.rs || (r_b.dest == w_b.rt && w_uses_rt));
    assign in_ready  = rst_n && !r_end && !w_hazard && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (wb_en && (wb_addr != '0 || ZERO_REG == 0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b         <= '0;
            r_out_valid <= 1'b0;
            r_end       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_b         <= w_b;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && w_end) r_end <= 1'b1;
        end
    end

    assign out_valid   = r_out_valid;
    assign end_program = r_end;
    assign opcode      = r_b.opcode;
    assign rs          = r_b.rs;
    assign rt          = r_b.rt;
    assign rd          = r_b.rd;
    assign shamt       = r_b.shamt;
    assign funct       = r_b.funct;
    assign imm         = r_b.imm;
    assign read_data_1 = r_b.rd1;
    assign read_data_2 = r_b.rd2;
    assign dest_reg    = r_b.dest;
    assign alu_op      = r_b.alu_op;
    assign illegal     = r_b.illegal;
    assign {reg_dest, branch, branch_ne, jump, mem_read, mem_to_reg, mem_write, alu_src, reg_write} = r_b.ctl;
endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p: random and directed stimulus checked against a behavioural decode model
module tb_decode_stage_p;
    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [31:0] imm, rd1, rd2;
        logic [4:0]  dest;
        logic        reg_dest, branch, branch_ne, jump, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
        logic [2:0]  alu_op;
        logic        illegal, endp;
    } bundle_t;

    logic        clk = 0, rst_n = 0, in_valid = 0, wb_en = 0, out_ready = 0;
    logic [31:0] instr = 0, wb_data = 0;
    logic [4:0]  wb_addr = 0;
    logic        in_ready, out_valid, reg_dest, branch, branch_ne, jump, mem_read, mem_to_reg;
    logic        mem_write, alu_src, reg_write, illegal, end_program;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt, dest_reg;
    logic [31:0] imm, read_data_1, read_data_2;
    logic [2:0]  alu_op;
    bundle_t     dut_b;
    int          n_pass = 0, n_total = 0;

    decode_stage_p dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .read_data_1(read_data_1), .read_data_2(read_data_2),
        .dest_reg(dest_reg), .reg_dest(reg_dest), .branch(branch), .branch_ne(branch_ne),
        .jump(jump), .mem_read(mem_read), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
        .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op), .illegal(illegal),
        .end_program(end_program)
    );

    always #5 clk = ~clk;

    assign dut_b = {out_valid, opcode, rs, rt, rd, shamt, funct, imm, read_data_1, read_data_2,
                    dest_reg, reg_dest, branch, branch_ne, jump, mem_read, mem_to_reg, mem_write,
                    alu_src, reg_write, alu_op, illegal, end_program};

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // behavioural model state
    bundle_t     m_out = '0, nxt;
    logic [31:0] m_regs [32] = '{default: 0};
    logic        m_end = 0, exp_rdy, s_acc, s_ordy, s_wb;
    logic [4:0]  s_wa;
    logic [31:0] s_wd;

    function automatic logic [31:0] rdreg(input logic [4:0] a);
        return (wb_en && wb_addr == a && a != 0) ? wb_data : m_regs[a];
    endfunction

    function automatic logic hz();
        logic [5:0] op = instr[31:26];
        return in_valid && m_out.valid && m_out.mem_read && m_out.dest != 0 &&
               (m_out.dest == instr[25:21] ||
                (m_out.dest == instr[20:16] && (op == 0 || op == 6'h2B || op == 6'h04 || op == 6'h05)));
    endfunction

    function automatic bundle_t decode(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        bundle_t     o  = '0;
        logic [31:0] se = {{16{i[15]}}, i[15:0]};
        logic [31:0] ze = {16'h0, i[15:0]};
        o.valid = 1; o.opcode = i[31:26]; o.rs = i[25:21]; o.rt = i[20:16]; o.rd = i[15:11];
        o.shamt = i[10:6]; o.funct = i[5:0]; o.rd1 = a; o.rd2 = b;
        case (i[31:26])
            6'h00: begin o.reg_dest = 1; o.reg_write = 1; o.alu_op = 2; end
            6'h23: begin o.mem_read = 1; o.mem_to_reg = 1; o.alu_src = 1; o.reg_write = 1; o.imm = se; end
            6'h2B: begin o.mem_write = 1; o.alu_src = 1; o.imm = se; end
            6'h04, 6'h05: begin o.branch = 1; o.branch_ne = i[26]; o.alu_op = 1; o.imm = se; end
            6'h08, 6'h0A: begin o.alu_src = 1; o.reg_write = 1; o.alu_op = i[27] ? 5 : 0; o.imm = se; end
            6'h0C, 6'h0D: begin o.alu_src = 1; o.reg_write = 1; o.alu_op = i[26] ? 4 : 3; o.imm = ze; end
            6'h0F: begin o.alu_src = 1; o.reg_write = 1; o.alu_op = 6; o.imm = {i[15:0], 16'h0}; end
            6'h02: begin o.jump = 1; o.imm = {6'h0, i[25:0]}; end
            6'h3F: ;
            default: o.illegal = 1;
        endcase
        o.dest = o.reg_dest ? o.rd : o.rt;
        return o;
    endfunction

    always begin
        @(negedge clk); #2;
        exp_rdy = rst_n && !m_end && !hz() && (!m_out.valid || out_ready);
        chk("in_ready", 256'(in_ready), 256'(exp_rdy));
        s_acc = in_valid && exp_rdy; s_ordy = out_ready; s_wb = wb_en; s_wa = wb_addr; s_wd = wb_data;
        nxt = decode(instr, rdreg(instr[25:21]), rdreg(instr[20:16]));
        @(posedge clk); #1;
        if (!rst_n) begin
            m_out = '0; m_end = 0; m_regs = '{default: 0};
        end else begin
            if (s_acc) begin m_out = nxt; m_end = m_end || nxt.opcode == 6'h3F; end
            else if (s_ordy) m_out.valid = 0;
            if (s_wb && s_wa != 0) m_regs[s_wa] = s_wd;
        end
        m_out.endp = m_end;
        chk("bundle", 256'(dut_b), 256'(m_out));
    end

    task automatic issue(input logic [31:0] ins, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        instr = ins; in_valid = 1; out_ready = 1; wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
        for (int k = 0; k < 10 && !in_ready; k++) begin @(negedge clk); #1; end
        chk("issue_ready", 256'(in_ready), 256'(1));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [13] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F, 6'h02, 6'h3E, 6'h01};
        logic [5:0] op = ops[$urandom_range(12)];
        return {op, 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)), 11'($urandom)};
    endfunction

    initial begin
        @(negedge clk);
        chk("reset_state", 256'({dut_b, in_ready}), 256'(0));
        @(negedge clk); rst_n = 1;
        wb_en = 1; wb_addr = 1; wb_data = 5;
        @(negedge clk); wb_addr = 2; wb_data = 7;
        issue(32'h00221820, 0, 0, 0);
        chk("add_fields", 256'({out_valid, rs, rt, rd, dest_reg, alu_op, reg_write}),
            256'({1'b1, 5'd1, 5'd2, 5'd3, 5'd3, 3'b010, 1'b1}));
        chk("add_rdata", 256'({read_data_1, read_data_2}), 256'({32'd5, 32'd7}));
        issue(32'h2004FFFF, 0, 0, 0);
        chk("addi_imm", 256'({imm, alu_src}), 256'({32'hFFFFFFFF, 1'b1}));
        @(negedge clk); instr = 32'h3484FFFF; out_ready = 0;
        repeat (3) begin
            #1 chk("bp_in_ready", 256'(in_ready), 256'(0));
            @(posedge clk); #1 chk("bp_hold", 256'({out_valid, opcode, imm}), 256'({1'b1, 6'h08, 32'hFFFFFFFF}));
            @(negedge clk);
        end
        out_ready = 1;
        #1 chk("bp_release", 256'(in_ready), 256'(1));
        @(posedge clk); #1 chk("ori_imm", 256'({out_valid, imm, alu_op}), 256'({1'b1, 32'h0000FFFF, 3'b100}));
        issue(32'h3C041234, 0, 0, 0);
        chk("lui_imm", 256'({imm, alu_op}), 256'({32'h12340000, 3'b110}));
        issue(32'h8C250000, 0, 0, 0);
        chk("lw_ctl", 256'({mem_read, mem_to_reg, dest_reg}), 256'({1'b1, 1'b1, 5'd5}));
        @(negedge clk); instr = 32'h00A23020;
        #1 chk("lu_stall", 256'(in_ready), 256'(0));
        @(posedge clk); #1 chk("lu_bubble", 256'(out_valid), 256'(0));
        @(negedge clk); #1 chk("lu_go", 256'(in_ready), 256'(1));
        @(posedge clk); #1 chk("lu_accept", 256'({out_valid, rs, rt, rd}), 256'({1'b1, 5'd5, 5'd2, 5'd6}));
        issue(32'h00021820, 1, 2, 32'hA5);
        chk("bypass_rt", 256'({read_data_1, read_data_2}), 256'({32'h0, 32'hA5}));
        issue(32'h00021820, 1, 0, 32'h55);
        chk("wb_zero", 256'({read_data_1, read_data_2}), 256'({32'h0, 32'hA5}));
        issue(32'h2004FFFF, 0, 0, 0);
        @(negedge clk); #3 rst_n = 0;
        #1 chk("async_reset", 256'({dut_b, in_ready}), 256'(0));
        @(negedge clk); rst_n = 1;
        issue(32'hF8000000, 0, 0, 0);
        chk("illegal", 256'({out_valid, illegal, reg_dest, branch, branch_ne, jump, mem_read, mem_to_reg,
                             mem_write, alu_src, reg_write, alu_op, imm}), 256'({2'b11, 44'h0}));
        issue(32'hFC000000, 0, 0, 0);
        chk("end_bundle", 256'({out_valid, end_program, illegal}), 256'(3'b110));
        @(negedge clk); instr = 32'h00221820;
        #1 chk("end_block", 256'(in_ready), 256'(0));
        @(posedge clk); #1 chk("end_sticky", 256'({out_valid, end_program}), 256'(2'b01));
        @(negedge clk); #1 chk("end_block2", 256'(in_ready), 256'(0));
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = $urandom_range(3) != 0;
            out_ready = $urandom_range(3) != 0;
            instr     = rand_instr();
            wb_en     = $urandom_range(1);
            wb_addr   = 5'($urandom_range(7));
            wb_data   = $urandom;
        end
        @(negedge clk); in_valid = 0; wb_en = 0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
